// File: rtl/gf_pkg.sv
// GF(2^M) helpers shared by the Chien search datapath.
// All arithmetic is carry-free and reduced modulo the field polynomial.
package gf_pkg;

    localparam int GF_M_DEF = 16;
    localparam int N_POINTS = (1 << GF_M_DEF) - 1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    function automatic logic [31:0] gf_mul(
        input logic [31:0] a,
        input logic [31:0] b,
        input int          m,
        input logic [32:0] poly
    );
        logic [32:0] x;
        logic [31:0] p;
        x = {1'b0, a};
        p = '0;
        for (int k = 0; k < 32; k++) begin
            if (k < m) begin
                if (((b >> k) & 32'd1) != 32'd0) p = p ^ x[31:0];
                x = x << 1;
                if ((x & (33'd1 << m)) != 33'd0) x = x ^ poly;
            end
        end
        return p;
    endfunction

    function automatic logic [31:0] gf_alpha_pow(
        input int          j,
        input int          m,
        input logic [32:0] poly
    );
        logic [31:0] r;
        r = 32'd1;
        for (int k = 0; k < j; k++) r = gf_mul(r, 32'd2, m, poly);
        return r;
    endfunction

endpackage

// File: rtl/chien_search_par_if.sv
// Request/result bundle of the Chien search block.
// master drives the request, slave is the search engine.
interface chien_search_par_if #(
    parameter int M  = 16,
    parameter int T  = 9,
    parameter int DW = $clog2(T + 1)
);
    logic                 start;
    logic [DW-1:0]        deg;
    logic [(T+1)*M-1:0]   sigma_poly;
    logic                 busy;
    logic                 eval_done;
    logic [T*M-1:0]       root_list;
    logic [DW-1:0]        root_cnt;
    logic                 root_fail;

    modport master (
        output start, deg, sigma_poly,
        input  busy, eval_done, root_list, root_cnt, root_fail
    );

    modport slave (
        input  start, deg, sigma_poly,
        output busy, eval_done, root_list, root_cnt, root_fail
    );
endinterface

// File: rtl/chien_search_par_gf_const_mul.sv
// Combinational multiply by an elaboration-time GF(2^M) constant.
// The constant folds away, leaving an XOR network.
module gf_const_mul
    import gf_pkg::*;
#(
    parameter int         M          = 16,
    parameter logic [M:0] FIELD_POLY = 17'h1002D,
    parameter logic [M-1:0] CONST    = M'(2)
) (
    input  logic [M-1:0] a,
    output logic [M-1:0] y
);
    assign y = M'(gf_mul(32'(a), 32'(CONST), M, 33'(FIELD_POLY)));
endmodule

// File: rtl/chien_search_par.sv
// Parallel Chien search over GF(2^M): one evaluation point per clock,
// two-stage pipeline, early exit once deg roots have been found.
module chien_search_par
    import gf_pkg::*;
#(
    parameter int         M          = 16,
    parameter int         T          = 9,
    parameter logic [M:0] FIELD_POLY = 17'h1002D,
    parameter int         DW         = $clog2(T + 1)
) (
    input logic               clk,
    input logic               rst_b,
    chien_search_par_if.slave bus
);
    localparam int           NP       = (1 << M) - 1;
    localparam logic [M-1:0] IDX_LAST = M'(NP - 1);
    localparam logic [M-1:0] IDX_END  = M'(NP);

    state_t         state, state_nx;
    logic [M-1:0]   term     [T+1];
    logic [M-1:0]   term_mul [1:T];
    logic [M-1:0]   sum_c, sum_reg, idx, idx_d;
    logic           v_d, busy_q, done_q, fail_q;
    logic           hit, last_pt;
    logic [DW-1:0]  deg_q, cnt_q;
    logic [T*M-1:0] list_q;

    function automatic logic deg_ok(input logic [DW-1:0] d);
        return (d != '0) && (int'(d) <= T);
    endfunction

    for (genvar j = 1; j <= T; j++) begin : g_mul
        gf_const_mul #(
            .M         (M),
            .FIELD_POLY(FIELD_POLY),
            .CONST     (M'(gf_alpha_pow(j, M, 33'(FIELD_POLY))))
        ) u_mul (
            .a(term[j]),
            .y(term_mul[j])
        );
    end

    always_comb begin
        sum_c = '0;
        for (int j = 0; j <= T; j++) sum_c = sum_c ^ term[j];
    end

    assign hit     = v_d && (sum_reg == '0) && (int'(cnt_q) < T);
    assign last_pt = v_d && (idx_d == IDX_LAST);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (bus.start) state_nx = deg_ok(bus.deg) ? SCAN : DONE;
            SCAN: begin
                if ((hit && (cnt_q + DW'(1) == deg_q)) || last_pt)
                    state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int j = 0; j <= T; j++) term[j] <= '0;
            sum_reg <= '0;
            idx     <= '0;
            idx_d   <= '0;
            v_d     <= 1'b0;
            deg_q   <= '0;
            cnt_q   <= '0;
            list_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        for (int j = 0; j <= T; j++)
                            term[j] <= bus.sigma_poly[j*M +: M];
                        deg_q  <= bus.deg;
                        list_q <= '0;
                        cnt_q  <= '0;
                        fail_q <= 1'b0;
                        idx    <= '0;
                        v_d    <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end
                SCAN: begin
                    // idx == IDX_END marks that every point has been issued
                    if (idx != IDX_END) begin
                        sum_reg <= sum_c;
                        idx_d   <= idx;
                        v_d     <= 1'b1;
                        for (int j = 1; j <= T; j++) term[j] <= term_mul[j];
                        idx     <= idx + M'(1);
                    end else begin
                        v_d <= 1'b0;
                    end
                    if (hit) begin
                        list_q <= (T*M)'({list_q, idx_d});
                        cnt_q  <= cnt_q + DW'(1);
                    end
                end
                DONE: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    v_d    <= 1'b0;
                    fail_q <= (cnt_q != deg_q) || !deg_ok(deg_q);
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.eval_done = done_q;
    assign bus.root_list = list_q;
    assign bus.root_cnt  = cnt_q;
    assign bus.root_fail = fail_q;
endmodule

// File: tb/tb_chien_search_par.sv
// Scoreboard bench for chien_search_par in GF(16) with T=3.
// Expected roots come from log/antilog table evaluation of sigma.
module tb_chien_search_par;
    localparam int         M    = 4;
    localparam int         T    = 3;
    localparam int         DW   = 2;
    localparam logic [4:0] POLY = 5'h13;
    localparam int         NP   = 15;

    typedef struct {
        logic [T*M-1:0] list;
        int             cnt;
        bit             fail;
        int             lat;
        int             t0;
    } exp_t;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   n_runs = 0;
    int   expt [NP];
    int   logt [16];
    exp_t sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    chien_search_par_if #(.M(M), .T(T), .DW(DW)) bus ();

    chien_search_par #(
        .M(M), .T(T), .FIELD_POLY(POLY), .DW(DW)
    ) dut (
        .clk  (clk),
        .rst_b(rst_b),
        .bus  (bus)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic void init_tables();
        int e = 1;
        for (int i = 0; i < NP; i++) begin
            expt[i] = e;
            logt[e] = i;
            e = e << 1;
            if ((e & 16) != 0) e = e ^ 'h13;
        end
    endfunction

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return expt[(logt[a] + logt[b]) % NP];
    endfunction

    function automatic exp_t model(input logic [(T+1)*M-1:0] sp, input int d);
        exp_t e;
        int   roots [$];
        e.list = '0;
        e.cnt  = 0;
        e.fail = 1'b1;
        e.lat  = 2;
        e.t0   = 0;
        if (d < 1 || d > T) return e;
        e.lat = NP + 3;
        for (int i = 0; i < NP; i++) begin
            int s = 0;
            for (int j = 0; j <= T; j++)
                s = s ^ gmul(int'(sp[j*M +: M]), expt[(i * j) % NP]);
            if (s == 0) begin
                roots.push_back(i);
                if (roots.size() == d) begin
                    e.lat = i + 4;
                    break;
                end
            end
        end
        e.cnt  = roots.size();
        e.fail = (e.cnt != d);
        foreach (roots[k])
            e.list[(roots.size() - 1 - k)*M +: M] = M'(roots[k]);
        return e;
    endfunction

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.eval_done, 0);
        chk({tag, "_list"}, bus.root_list, 0);
        chk({tag, "_cnt"}, bus.root_cnt, 0);
        chk({tag, "_fail"}, bus.root_fail, 0);
    endtask

    task automatic run(input logic [(T+1)*M-1:0] sp, input int d,
                       input bit spam);
        exp_t e;
        int   seen;
        e = model(sp, d);
        @(negedge clk);
        bus.sigma_poly = sp;
        bus.deg        = DW'(d);
        bus.start      = 1'b1;
        e.t0 = cyc;
        sb.push_back(e);
        n_runs++;
        seen = done_cnt;
        @(negedge clk);
        if (!spam) bus.start = 1'b0;
        chk("busy_after_start", bus.busy, 1);
        if (spam) begin
            repeat (15) @(negedge clk);
            bus.start = 1'b0;
        end
        for (int k = 0; k < 40 && done_cnt == seen; k++) begin
            @(negedge clk);
            #1;
        end
        chk("done_seen", done_cnt - seen, 1);
        repeat (3) @(negedge clk);
    endtask

    // monitor: pops the scoreboard on each eval_done pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_b && bus.eval_done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=pulse required=none");
                end else begin
                    e = sb.pop_front();
                    chk("root_list", bus.root_list, e.list);
                    chk("root_cnt", bus.root_cnt, e.cnt);
                    chk("root_fail", bus.root_fail, e.fail);
                    chk("latency", cyc - e.t0, e.lat);
                    chk("busy_at_done", bus.busy, 0);
                end
            end
        end
    end

    initial begin
        exp_t e;
        logic [(T+1)*M-1:0] sp;
        int d;
        init_tables();
        bus.start      = 1'b0;
        bus.deg        = '0;
        bus.sigma_poly = '0;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        rst_b = 1'b1;

        run(16'h0231, 2, 1'b0);
        run(16'h0111, 2, 1'b0);
        run(16'h0001, 1, 1'b0);
        run(16'h0231, 0, 1'b0);
        run(16'h0231, 2, 1'b1);

        @(negedge clk);
        bus.sigma_poly = 16'h0231;
        bus.deg        = 2'd2;
        bus.start      = 1'b1;
        e = model(16'h0231, 2);
        e.t0 = cyc;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        chk("mid_scan_cnt", bus.root_cnt, 1);
        chk("mid_scan_busy", bus.busy, 1);
        #2 rst_b = 1'b0;
        #1;
        chk_zero_outputs("async_reset");
        sb.delete(sb.size() - 1);
        @(negedge clk);
        rst_b = 1'b1;
        run(16'h0231, 2, 1'b0);

        for (int r = 0; r < 40; r++) begin
            d  = $urandom_range(0, T);
            sp = '0;
            for (int j = 0; j <= T; j++)
                if (j <= d) sp[j*M +: M] = M'($urandom_range(0, NP));
            run(sp, d, 1'b0);
        end

        repeat (5) @(negedge clk);
        chk("done_pulses", done_cnt, n_runs);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
